sd_modu: RTL and testbench



---
 rtl/sd_modu.sv | 35 +++
 tb/tb_sd_modu.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sd_modu.sv
`default_nettype none
// ============================================================================
// sd_modu : first-order sigma-delta modulator, N-bit unsigned sample to 1-bit PDM
// Revision: 1.0
// ============================================================================
module sd_modu #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         areset,
  input  logic [N-1:0] din,
  output logic         pdm
);

  logic [N-1:0] r_acc;
  logic         r_pdm;
  logic [N:0]   w_sum;

  // The carry out of the modulo-2^N accumulation is the output bit.
  assign w_sum = {1'b0, r_acc} + {1'b0, din};

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_acc <= '0;
      r_pdm <= 1'b0;
    end else begin
      r_acc <= w_sum[N-1:0];
      r_pdm <= w_sum[N];
    end
  end

  assign pdm = r_pdm;

endmodule
`default_nettype wire

// File: tb/tb_sd_modu.sv
`default_nettype none
// ============================================================================
// tb_sd_modu : directed-vector bench for sd_modu
// Revision: 1.0
// ============================================================================
module tb_sd_modu;

  logic        clk;
  logic        areset;
  logic [15:0] din;
  logic        pdm;

  int n_total;
  int n_bad;

  sd_modu #(.N(16)) u_dut (
    .clk    (clk),
    .areset (areset),
    .din    (din),
    .pdm    (pdm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [7:0]  exp_bits;  // MSB = pdm after first edge following release
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hold reset for a few edges with din applied, then release at a falling edge.
  task automatic reset_and_start(input logic [15:0] d);
    @(negedge clk);
    areset = 1'b0;
    din    = d;
    repeat (3) @(negedge clk);
    chk("reset_hold_pdm", {31'd0, pdm}, 32'd0);
    areset = 1'b1;
  endtask

  initial begin
    logic [15:0] rnd;
    logic [15:0] d_rand;
    int          ones;

    n_total = 0;
    n_bad   = 0;
    areset  = 1'b0;
    din     = 16'h8000;

    vecs[0] = '{16'h8000, 8'b01010101};
    vecs[1] = '{16'h4000, 8'b00010001};
    vecs[2] = '{16'hC000, 8'b01110111};
    vecs[3] = '{16'h0000, 8'b00000000};
    vecs[4] = '{16'h2000, 8'b00000001};
    vecs[5] = '{16'hA000, 8'b01011011};

    // Reset held low with clocks running and a non-zero input.
    repeat (4) begin
      @(negedge clk);
      chk("reset_state_pdm", {31'd0, pdm}, 32'd0);
    end

    // Table-driven: each vector restarts from acc=0.
    for (int v = 0; v < 6; v++) begin
      reset_and_start(vecs[v].din);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk($sformatf("vec%0d_din%04h_edge%0d", v, vecs[v].din, k + 1),
            {31'd0, pdm}, {31'd0, vecs[v].exp_bits[7-k]});
      end
    end

    // Asynchronous reset mid-cycle while pdm is high.
    reset_and_start(16'h8000);
    @(negedge clk);
    @(negedge clk);
    chk("async_pre_pdm", {31'd0, pdm}, 32'd1);
    #2 areset = 1'b0;
    #1 chk("async_clear_pdm", {31'd0, pdm}, 32'd0);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    chk("async_restart_edge1", {31'd0, pdm}, 32'd0);
    @(negedge clk);
    chk("async_restart_edge2", {31'd0, pdm}, 32'd1);

    // Input change mid-stream: residue carries over, then trailing zeros.
    reset_and_start(16'h8000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stream_a_edge%0d", k + 1), {31'd0, pdm}, {31'd0, (k == 1)});
    end
    din = 16'h4000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("stream_b_edge%0d", k + 1), {31'd0, pdm}, {31'd0, (k == 1 || k == 5)});
    end
    din = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("stream_zero_edge%0d", k + 1), {31'd0, pdm}, 32'd0);
    end

    // Full scale from reset: 0 first, then 65535 ones, then a single 0.
    reset_and_start(16'hFFFF);
    @(negedge clk);
    chk("full_first_pdm", {31'd0, pdm}, 32'd0);
    ones = 0;
    for (int k = 0; k < 65535; k++) begin
      @(negedge clk);
      ones += int'(pdm);
    end
    chk("full_ones_count", ones, 32'd65535);
    @(negedge clk);
    chk("full_wrap_pdm", {31'd0, pdm}, 32'd0);

    // Density: din multiple of 16 has period 4096, so ones over 4096 cycles = din/16.
    rnd    = 16'($urandom_range(1, 4095));
    d_rand = {rnd[11:0], 4'h0};
    din    = d_rand;
    ones   = 0;
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk);
      ones += int'(pdm);
    end
    chk($sformatf("density_din%04h", d_rand), ones, {20'd0, rnd[11:0]});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
